hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 124 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller for the LC-3b pipeline: tracks in-flight register
// and CC writes, detects RAW/saturation/control hazards and drives stall/bubble/issue.
module hazard_scoreboard #(
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned PERF_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dec_valid,
    input  logic [2:0]        dec_src1,
    input  logic [2:0]        dec_src2,
    input  logic              dec_src1_used,
    input  logic              dec_src2_used,
    input  logic [2:0]        dec_dest,
    input  logic              dec_wr_reg,
    input  logic              dec_wr_cc,
    input  logic              dec_rd_cc,
    input  logic              dec_is_ctrl,
    input  logic              wb_valid,
    input  logic [2:0]        wb_dest,
    input  logic              wb_wr_reg,
    input  logic              wb_wr_cc,
    input  logic              mem_stall,
    input  logic              ctrl_resolved,
    output logic              issue,
    output logic              bubble,
    output logic              stall_decode,
    output logic              stall_fetch,
    output logic [7:0]        busy_mask,
    output logic              cc_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int unsigned NUM_REGS = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {RUN, CTRL_WAIT} state_t;

    state_t                            state_q, state_d;
    logic [NUM_REGS-1:0][CNT_W-1:0]    reg_cnt_q, reg_cnt_d;
    logic [CNT_W-1:0]                  cc_cnt_q, cc_cnt_d;
    logic [PERF_W-1:0]                 stall_cycles_q, stall_cycles_d;

    logic raw_hz;
    logic sat_hz;
    logic stall_event;

    // Hazards are evaluated against pre-writeback counts (no regfile write-through).
    always_comb begin
        raw_hz = (dec_src1_used && (reg_cnt_q[dec_src1] != '0)) ||
                 (dec_src2_used && (reg_cnt_q[dec_src2] != '0)) ||
                 (dec_rd_cc     && (cc_cnt_q != '0));
        sat_hz = (dec_wr_reg && (reg_cnt_q[dec_dest] == CNT_MAX)) ||
                 (dec_wr_cc  && (cc_cnt_q == CNT_MAX));
        issue        = dec_valid && (state_q == RUN) && !mem_stall && !raw_hz && !sat_hz;
        bubble       = !issue && !mem_stall;
        stall_decode = (dec_valid && !issue) || mem_stall;
        stall_fetch  = stall_decode || (state_q == CTRL_WAIT);
        stall_event  = dec_valid && !mem_stall && (raw_hz || sat_hz || (state_q == CTRL_WAIT));
    end

    // Pending counters: simultaneous issue and retire on one destination cancel out.
    always_comb begin
        logic inc;
        logic dec;
        reg_cnt_d = reg_cnt_q;
        cc_cnt_d  = cc_cnt_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            inc = issue && dec_wr_reg && (dec_dest == 3'(i));
            dec = wb_valid && wb_wr_reg && (wb_dest == 3'(i));
            if (inc && !dec) begin
                reg_cnt_d[i] = reg_cnt_q[i] + CNT_W'(1);
            end else if (dec && !inc && (reg_cnt_q[i] != '0)) begin
                reg_cnt_d[i] = reg_cnt_q[i] - CNT_W'(1);
            end
        end
        inc = issue && dec_wr_cc;
        dec = wb_valid && wb_wr_cc;
        if (inc && !dec) begin
            cc_cnt_d = cc_cnt_q + CNT_W'(1);
        end else if (dec && !inc && (cc_cnt_q != '0)) begin
            cc_cnt_d = cc_cnt_q - CNT_W'(1);
        end
    end

    // Control-transfer FSM and saturating stall counter.
    always_comb begin
        state_d        = state_q;
        stall_cycles_d = stall_cycles_q;
        case (state_q)
            RUN:       if (issue && dec_is_ctrl) state_d = CTRL_WAIT;
            CTRL_WAIT: if (ctrl_resolved)        state_d = RUN;
            default:                             state_d = RUN;
        endcase
        if (stall_event && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RUN;
            reg_cnt_q      <= '0;
            cc_cnt_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            reg_cnt_q      <= reg_cnt_d;
            cc_cnt_q       <= cc_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            busy_mask[i] = (reg_cnt_q[i] != '0);
        end
    end

    assign cc_busy      = (cc_cnt_q != '0);
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dec_valid, dec_src1_used, dec_src2_used;
    logic [2:0]  dec_src1, dec_src2, dec_dest, wb_dest;
    logic        dec_wr_reg, dec_wr_cc, dec_rd_cc, dec_is_ctrl;
    logic        wb_valid, wb_wr_reg, wb_wr_cc, mem_stall, ctrl_resolved;
    logic        issue, bubble, stall_decode, stall_fetch, cc_busy;
    logic [7:0]  busy_mask;
    logic [15:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    hazard_scoreboard #(.CNT_W(2), .PERF_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .dec_valid(dec_valid), .dec_src1(dec_src1), .dec_src2(dec_src2),
        .dec_src1_used(dec_src1_used), .dec_src2_used(dec_src2_used),
        .dec_dest(dec_dest), .dec_wr_reg(dec_wr_reg), .dec_wr_cc(dec_wr_cc),
        .dec_rd_cc(dec_rd_cc), .dec_is_ctrl(dec_is_ctrl),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_wr_reg(wb_wr_reg), .wb_wr_cc(wb_wr_cc),
        .mem_stall(mem_stall), .ctrl_resolved(ctrl_resolved),
        .issue(issue), .bubble(bubble), .stall_decode(stall_decode), .stall_fetch(stall_fetch),
        .busy_mask(busy_mask), .cc_busy(cc_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_in();
        dec_valid = 0; dec_src1 = 0; dec_src2 = 0; dec_src1_used = 0; dec_src2_used = 0;
        dec_dest = 0; dec_wr_reg = 0; dec_wr_cc = 0; dec_rd_cc = 0; dec_is_ctrl = 0;
        wb_valid = 0; wb_dest = 0; wb_wr_reg = 0; wb_wr_cc = 0;
        mem_stall = 0; ctrl_resolved = 0;
    endtask

    task automatic writer(input logic [2:0] d);
        clr_in();
        dec_valid = 1; dec_wr_reg = 1; dec_dest = d;
    endtask

    task automatic retire(input logic [2:0] d);
        clr_in();
        wb_valid = 1; wb_wr_reg = 1; wb_dest = d;
    endtask

    initial begin
        clr_in();
        reset_n = 0;
        // Reset: combinational issue follows dec_valid, state stays zeroed.
        writer(3'd3);
        settle();
        chk("rst_issue", 32'(issue), 32'd1);
        tick(); tick();
        chk("rst_busy", 32'(busy_mask), 32'h00);
        chk("rst_cc_busy", 32'(cc_busy), 32'd0);
        chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        clr_in();
        reset_n = 1;
        tick();
        chk("rel_busy", 32'(busy_mask), 32'h00);

        // RAW on R3 (+CC), writeback at cycle t, consumer issues at t+1.
        writer(3'd3); dec_wr_cc = 1;
        settle();
        chk("raw_prod_issue", 32'(issue), 32'd1);
        tick();
        chk("raw_busy", 32'(busy_mask), 32'h08);
        chk("raw_cc_busy", 32'(cc_busy), 32'd1);
        writer(3'd4); dec_src1 = 3'd3; dec_src1_used = 1;
        settle();
        chk("raw_issue0", 32'(issue), 32'd0);
        chk("raw_stall_dec", 32'(stall_decode), 32'd1);
        chk("raw_bubble", 32'(bubble), 32'd1);
        chk("raw_stall_fetch", 32'(stall_fetch), 32'd1);
        tick();
        wb_valid = 1; wb_dest = 3'd3; wb_wr_reg = 1; wb_wr_cc = 1;
        settle();
        chk("raw_wb_cycle_issue", 32'(issue), 32'd0);
        tick();
        wb_valid = 0; wb_wr_reg = 0; wb_wr_cc = 0;
        settle();
        chk("raw_after_wb_issue", 32'(issue), 32'd1);
        chk("raw_stall_cnt", 32'(stall_cycles), 32'd2);
        chk("raw_cc_clear", 32'(cc_busy), 32'd0);
        tick();
        chk("raw_busy_r4", 32'(busy_mask), 32'h10);

        // Same-cycle increment and decrement on R1.
        writer(3'd1);
        tick();
        chk("inc_busy", 32'(busy_mask), 32'h12);
        writer(3'd1); wb_valid = 1; wb_wr_reg = 1; wb_dest = 3'd1;
        settle();
        chk("incdec_issue", 32'(issue), 32'd1);
        tick();
        chk("incdec_busy", 32'(busy_mask), 32'h12);
        retire(3'd1);
        tick();
        chk("r1_drain", 32'(busy_mask), 32'h10);
        retire(3'd4);
        tick();
        chk("r4_drain", 32'(busy_mask), 32'h00);

        // Saturation: three writers to R5 fill the counter.
        for (int i = 0; i < 3; i++) begin
            writer(3'd5);
            settle();
            chk("sat_fill_issue", 32'(issue), 32'd1);
            tick();
        end
        chk("sat_busy", 32'(busy_mask), 32'h20);
        writer(3'd5);
        settle();
        chk("sat_issue0", 32'(issue), 32'd0);
        chk("sat_stall_dec", 32'(stall_decode), 32'd1);
        tick();
        wb_valid = 1; wb_wr_reg = 1; wb_dest = 3'd5;
        settle();
        chk("sat_wb_cycle_issue", 32'(issue), 32'd0);
        tick();
        wb_valid = 0;
        settle();
        chk("sat_next_issue", 32'(issue), 32'd1);
        chk("sat_stall_cnt", 32'(stall_cycles), 32'd4);
        tick();
        for (int i = 0; i < 3; i++) begin
            retire(3'd5);
            tick();
        end
        chk("sat_drain", 32'(busy_mask), 32'h00);

        // Control: ctrl_resolved in RUN ignored; BR enters CTRL_WAIT.
        clr_in(); ctrl_resolved = 1;
        tick();
        clr_in(); dec_valid = 1; dec_rd_cc = 1; dec_is_ctrl = 1;
        settle();
        chk("br_issue", 32'(issue), 32'd1);
        chk("br_stall_fetch_run", 32'(stall_fetch), 32'd0);
        tick();
        clr_in();
        settle();
        chk("cw_idle_issue", 32'(issue), 32'd0);
        chk("cw_idle_stall_dec", 32'(stall_decode), 32'd0);
        chk("cw_idle_stall_fetch", 32'(stall_fetch), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            clr_in(); dec_valid = 1;
            settle();
            chk("cw_issue", 32'(issue), 32'd0);
            chk("cw_stall_fetch", 32'(stall_fetch), 32'd1);
            chk("cw_bubble", 32'(bubble), 32'd1);
            tick();
        end
        chk("cw_stall_cnt", 32'(stall_cycles), 32'd7);
        clr_in(); dec_valid = 1; ctrl_resolved = 1;
        settle();
        chk("cw_resolve_issue", 32'(issue), 32'd0);
        tick();
        ctrl_resolved = 0;
        settle();
        chk("cw_resume_issue", 32'(issue), 32'd1);
        chk("cw_resume_fetch", 32'(stall_fetch), 32'd0);
        chk("cw_resume_cnt", 32'(stall_cycles), 32'd8);
        tick();

        // mem_stall during a RAW stall on R2.
        writer(3'd2);
        tick();
        clr_in(); dec_valid = 1; dec_src2 = 3'd2; dec_src2_used = 1;
        settle();
        chk("ms_raw_issue", 32'(issue), 32'd0);
        tick();
        mem_stall = 1; wb_valid = 1; wb_wr_reg = 1; wb_dest = 3'd2;
        settle();
        chk("ms_bubble", 32'(bubble), 32'd0);
        chk("ms_stall_dec", 32'(stall_decode), 32'd1);
        chk("ms_issue", 32'(issue), 32'd0);
        tick();
        wb_valid = 0; wb_wr_reg = 0;
        settle();
        chk("ms_wb_clears", 32'(busy_mask), 32'h00);
        chk("ms_issue_blocked", 32'(issue), 32'd0);
        tick();
        mem_stall = 0;
        settle();
        chk("ms_release_issue", 32'(issue), 32'd1);
        chk("ms_stall_cnt", 32'(stall_cycles), 32'd9);
        tick();

        // Mid-operation reset discards pending writes and CTRL_WAIT.
        writer(3'd6); dec_is_ctrl = 1; dec_wr_cc = 1;
        tick();
        chk("mr_busy_pre", 32'(busy_mask), 32'h40);
        clr_in();
        reset_n = 0;
        settle();
        chk("mr_busy", 32'(busy_mask), 32'h00);
        chk("mr_cc_busy", 32'(cc_busy), 32'd0);
        chk("mr_stall_cnt", 32'(stall_cycles), 32'd0);
        tick();
        reset_n = 1;
        clr_in(); dec_valid = 1; dec_src1 = 3'd6; dec_src1_used = 1; dec_rd_cc = 1;
        settle();
        chk("mr_issue", 32'(issue), 32'd1);
        chk("mr_stall_fetch", 32'(stall_fetch), 32'd0);
        tick();
        clr_in();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
